bus_uart_tx: RTL and testbench

- Memory-mapped UART transmitter that sits on the core's data bus, downstream of the data memory interface.
- Decodes a 16-byte window, buffers written bytes in a FIFO and serialises them as 8N1 on `tx`.
- Register reads are combinational so the single-cycle core gets read data in the same cycle.
- `bus_read_data` is zero when the block is not selected, so the interconnect can OR it with other slaves.

---
 rtl/bus_uart_pkg.sv | 31 +++
 rtl/bus_uart_tx_if.sv | 39 +++
 rtl/uart_tx_fifo.sv | 76 +++++++
 rtl/bus_uart_tx.sv | 244 ++++++++++++++++++++++++
 tb/tb_bus_uart_tx.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/bus_uart_pkg.sv
// -----------------------------------------------------------------------------
// bus_uart_pkg
// Shared definitions for the memory-mapped UART transmitter:
//   - word offsets (address bits [3:2]) of the register window
//   - bit positions inside the STATUS register
//   - serialiser state encoding
// No ports; imported by bus_uart_tx.
// -----------------------------------------------------------------------------
package bus_uart_pkg;

    // Register word offsets, compared against bus_address[3:2]
    localparam logic [1:0] OFF_DATA     = 2'd0;
    localparam logic [1:0] OFF_STATUS   = 2'd1;
    localparam logic [1:0] OFF_DIVISOR  = 2'd2;
    localparam logic [1:0] OFF_RESERVED = 2'd3;

    // STATUS register bit positions
    localparam int STAT_TX_DONE   = 0;
    localparam int STAT_FULL      = 1;
    localparam int STAT_OVERFLOW  = 2;
    localparam int STAT_COUNT_LSB = 8;   // FIFO count occupies [15:8]

    // Serialiser states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_e;

endpackage

// File: rtl/bus_uart_tx_if.sv
// -----------------------------------------------------------------------------
// bus_uart_tx_if
// Core data-bus signals seen by the UART transmitter.
//   bus_address      byte address from the core
//   bus_read_data    combinational read data (zero when slave not selected)
//   bus_write_data   write data
//   bus_byte_enable  byte lane enables
//   bus_read_enable  read strobe
//   bus_write_enable write strobe
// Modports: master (core / interconnect side), slave (UART side).
// -----------------------------------------------------------------------------
interface bus_uart_tx_if;

    logic [31:0] bus_address;
    logic [31:0] bus_read_data;
    logic [31:0] bus_write_data;
    logic [3:0]  bus_byte_enable;
    logic        bus_read_enable;
    logic        bus_write_enable;

    modport master (
        output bus_address,
        output bus_write_data,
        output bus_byte_enable,
        output bus_read_enable,
        output bus_write_enable,
        input  bus_read_data
    );

    modport slave (
        input  bus_address,
        input  bus_write_data,
        input  bus_byte_enable,
        input  bus_read_enable,
        input  bus_write_enable,
        output bus_read_data
    );

endinterface

// File: rtl/uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo
// Synchronous FIFO buffering bytes between the bus write port and the
// serialiser.
//   clock, reset  system clock, asynchronous active-high reset
//   push          write request; ignored while full
//   push_data     data to write
//   pop           read request; ignored while empty
//   pop_data      head entry (valid whenever empty is low)
//   count         number of stored entries, 0..DEPTH
//   full, empty   occupancy flags derived from the registered count
// DEPTH must be a power of two (>= 2) so the pointers wrap naturally.
// -----------------------------------------------------------------------------
module uart_tx_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_push_ok;
    logic             w_pop_ok;

    assign full      = (r_count == CW'(DEPTH));
    assign empty     = (r_count == '0);
    assign count     = r_count;
    assign w_push_ok = push && !full;
    assign w_pop_ok  = pop && !empty;
    assign pop_data  = r_mem[r_rd_ptr];

    // NOTE: storage has no reset; only pointers and count define validity,
    // and leaving the array unreset lets it map onto plain register files.
    always_ff @(posedge clock) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;   // none, or push+pop cancel
            endcase
        end
    end

endmodule

// File: rtl/bus_uart_tx.sv
// -----------------------------------------------------------------------------
// bus_uart_tx
// Memory-mapped 8N1 UART transmitter on the core data bus.
//   clock, reset  system clock, asynchronous active-high reset
//   bus           bus_uart_tx_if.slave: address/data/strobes, read data
//   tx            serial output, idles high, driven from a flop
//   tx_irq        high while the FIFO is empty and the serialiser is idle
// Register window (16 bytes at BASE_ADDRESS, word offset = address[3:2]):
//   0x0 DATA     write pushes byte lane 0 into the TX FIFO; reads 0
//   0x4 STATUS   [0] tx_done [1] full [2] overflow (W1C) [15:8] count
//   0x8 DIVISOR  [15:0] bit time minus one, byte-lane writable
//   0xC reserved
// Reads are combinational and return zero when not selected, so the
// interconnect can OR slave read buses together.
// -----------------------------------------------------------------------------
module bus_uart_tx
    import bus_uart_pkg::*;
#(
    parameter logic [31:0] BASE_ADDRESS    = 32'h1000_0000,
    parameter int          FIFO_DEPTH      = 8,
    parameter logic [15:0] DEFAULT_DIVISOR = 16'd3
) (
    input  logic         clock,
    input  logic         reset,
    bus_uart_tx_if.slave bus,
    output logic         tx,
    output logic         tx_irq
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic       w_sel;
    logic [1:0] w_offset;
    logic       w_wr;
    logic       w_push;
    logic       w_div_wr;
    logic       w_ovf_clr;

    assign w_sel     = (bus.bus_address[31:4] == BASE_ADDRESS[31:4]);
    assign w_offset  = bus.bus_address[3:2];
    assign w_wr      = w_sel && bus.bus_write_enable;
    assign w_push    = w_wr && (w_offset == OFF_DATA) && bus.bus_byte_enable[0];
    assign w_div_wr  = w_wr && (w_offset == OFF_DIVISOR);
    assign w_ovf_clr = w_wr && (w_offset == OFF_STATUS) && bus.bus_byte_enable[0]
                       && bus.bus_write_data[STAT_OVERFLOW];

    // Bits that the register map deliberately ignores
    logic w_unused_bits;
    assign w_unused_bits = ^{bus.bus_address[1:0], bus.bus_write_data[31:16],
                             bus.bus_byte_enable[3:2]};

    // ------------------------------------------------------------------
    // FIFO
    // ------------------------------------------------------------------
    logic          w_pop;
    logic [7:0]    w_pop_data;
    logic [CW-1:0] w_count;
    logic          w_full;
    logic          w_empty;

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (w_push),
        .push_data (bus.bus_write_data[7:0]),
        .pop       (w_pop),
        .pop_data  (w_pop_data),
        .count     (w_count),
        .full      (w_full),
        .empty     (w_empty)
    );

    // ------------------------------------------------------------------
    // DIVISOR and overflow registers
    // ------------------------------------------------------------------
    logic [15:0] r_divisor;
    logic        r_overflow;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_divisor <= DEFAULT_DIVISOR;
        end else if (w_div_wr) begin
            if (bus.bus_byte_enable[0]) r_divisor[7:0]  <= bus.bus_write_data[7:0];
            if (bus.bus_byte_enable[1]) r_divisor[15:8] <= bus.bus_write_data[15:8];
        end
    end

    // The full flag is the registered occupancy, so a push that coincides
    // with a pop from a full FIFO is still dropped and still flagged.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_overflow <= 1'b0;
        end else if (w_push && w_full) begin
            r_overflow <= 1'b1;
        end else if (w_ovf_clr) begin
            r_overflow <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Serialiser FSM
    // ------------------------------------------------------------------
    tx_state_e   r_state,   w_state_next;
    logic [7:0]  r_shift,   w_shift_next;
    logic [15:0] r_bit_div, w_bit_div_next;   // divisor frozen for this frame
    logic [15:0] r_bit_cnt, w_bit_cnt_next;
    logic [2:0]  r_bit_idx, w_bit_idx_next;
    logic        r_tx,      w_tx_next;
    logic        w_bit_end;

    assign w_bit_end = (r_bit_cnt == r_bit_div);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state   <= IDLE;
            r_shift   <= '0;
            r_bit_div <= '0;
            r_bit_cnt <= '0;
            r_bit_idx <= '0;
            r_tx      <= 1'b1;
        end else begin
            r_state   <= w_state_next;
            r_shift   <= w_shift_next;
            r_bit_div <= w_bit_div_next;
            r_bit_cnt <= w_bit_cnt_next;
            r_bit_idx <= w_bit_idx_next;
            r_tx      <= w_tx_next;
        end
    end

    // w_tx_next always carries the level of the bit that starts at the next
    // edge, so tx comes straight from a flop.
    // NOTE: every output of this block gets a default before the case so no
    // path leaves a signal unassigned, which would infer a latch.
    always_comb begin
        w_state_next   = r_state;
        w_shift_next   = r_shift;
        w_bit_div_next = r_bit_div;
        w_bit_cnt_next = r_bit_cnt + 16'd1;
        w_bit_idx_next = r_bit_idx;
        w_tx_next      = r_tx;
        w_pop          = 1'b0;

        case (r_state)
            IDLE: begin
                w_tx_next      = 1'b1;
                w_bit_cnt_next = '0;
                if (!w_empty) begin
                    w_pop          = 1'b1;
                    w_shift_next   = w_pop_data;
                    w_bit_div_next = r_divisor;
                    w_state_next   = START;
                    w_tx_next      = 1'b0;
                end
            end

            START: begin
                if (w_bit_end) begin
                    w_bit_cnt_next = '0;
                    w_bit_idx_next = '0;
                    w_state_next   = DATA;
                    w_tx_next      = r_shift[0];
                end
            end

            DATA: begin
                if (w_bit_end) begin
                    w_bit_cnt_next = '0;
                    w_shift_next   = {1'b0, r_shift[7:1]};
                    if (r_bit_idx == 3'd7) begin
                        w_state_next = STOP;
                        w_tx_next    = 1'b1;
                    end else begin
                        w_bit_idx_next = r_bit_idx + 3'd1;
                        w_tx_next      = r_shift[1];
                    end
                end
            end

            STOP: begin
                if (w_bit_end) begin
                    w_bit_cnt_next = '0;
                    if (!w_empty) begin
                        // Chain straight into the next start bit
                        w_pop          = 1'b1;
                        w_shift_next   = w_pop_data;
                        w_bit_div_next = r_divisor;
                        w_state_next   = START;
                        w_tx_next      = 1'b0;
                    end else begin
                        w_state_next = IDLE;
                        w_tx_next    = 1'b1;
                    end
                end
            end

            default: begin
                w_state_next = IDLE;
                w_tx_next    = 1'b1;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Status, read mux, outputs
    // ------------------------------------------------------------------
    logic        w_tx_done;
    logic [31:0] w_status;
    logic [31:0] w_rdata;

    assign w_tx_done = w_empty && (r_state == IDLE);

    always_comb begin
        w_status                          = '0;
        w_status[STAT_TX_DONE]            = w_tx_done;
        w_status[STAT_FULL]               = w_full;
        w_status[STAT_OVERFLOW]           = r_overflow;
        w_status[STAT_COUNT_LSB +: 8]     = 8'(w_count);
    end

    always_comb begin
        w_rdata = '0;
        if (w_sel && bus.bus_read_enable) begin
            case (w_offset)
                OFF_STATUS:   w_rdata = w_status;
                OFF_DIVISOR:  w_rdata = {16'h0000, r_divisor};
                OFF_DATA,
                OFF_RESERVED: w_rdata = '0;
                default:      w_rdata = '0;
            endcase
        end
    end

    assign bus.bus_read_data = w_rdata;
    assign tx                = r_tx;
    assign tx_irq            = w_tx_done;

endmodule

// File: tb/tb_bus_uart_tx.sv
module tb_bus_uart_tx;

    localparam logic [31:0] A_DATA   = 32'h1000_0000;
    localparam logic [31:0] A_STATUS = 32'h1000_0004;
    localparam logic [31:0] A_DIV    = 32'h1000_0008;
    localparam logic [31:0] A_RSVD   = 32'h1000_000C;

    logic clock;
    logic reset;
    logic tx;
    logic tx_irq;
    int   errors;
    int   checks;

    bus_uart_tx_if bus_if ();

    bus_uart_tx #(
        .BASE_ADDRESS    (32'h1000_0000),
        .FIFO_DEPTH      (8),
        .DEFAULT_DIVISOR (16'd3)
    ) dut (
        .clock  (clock),
        .reset  (reset),
        .bus    (bus_if),
        .tx     (tx),
        .tx_irq (tx_irq)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- bus helpers ----------------
    task automatic bus_write(input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] be);
        bus_if.bus_address      = addr;
        bus_if.bus_write_data   = data;
        bus_if.bus_byte_enable  = be;
        bus_if.bus_write_enable = 1'b1;
        @(posedge clock);
        #1;
        bus_if.bus_write_enable = 1'b0;
        bus_if.bus_byte_enable  = 4'b0000;
    endtask

    task automatic bus_read(input logic [31:0] addr, input logic re,
                            output logic [31:0] data);
        bus_if.bus_address     = addr;
        bus_if.bus_read_enable = re;
        #1;
        data = bus_if.bus_read_data;
        bus_if.bus_read_enable = 1'b0;
    endtask

    task automatic check_read(input logic [31:0] addr, input logic [31:0] exp,
                              input string name);
        logic [31:0] got;
        bus_read(addr, 1'b1, got);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: read 0x%08h expected 0x%08h", name, got, exp);
        end
    endtask

    task automatic check_bit(input logic got, input logic exp, input string name);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, got, exp);
        end
    endtask

    // Wait (bounded) until tx drops; leaves time in the first start-bit cycle.
    task automatic wait_start(input string name);
        int n;
        n = 0;
        while (tx !== 1'b0 && n < 6) begin
            @(posedge clock);
            #1;
            n++;
        end
        checks++;
        if (tx !== 1'b0) begin
            errors++;
            $display("FAIL %s: no start bit within %0d clocks, tx=%b", name, n, tx);
        end
    endtask

    // Check a whole 8N1 frame, one comparison per bit slot.
    // cur >= 0: the current time is already in frame cycle 'cur'.
    // cur <  0: the frame begins at the next clock edge.
    task automatic expect_frame(input logic [7:0] b, input int div, input int cur,
                                input string name);
        logic [9:0] bits;
        int         len;
        int         first;
        logic       slot_ok;
        logic       bad_val;
        bits    = {1'b1, b, 1'b0};
        len     = 10 * (div + 1);
        first   = (cur < 0) ? 0 : cur;
        slot_ok = 1'b1;
        bad_val = 1'b0;
        for (int i = first; i < len; i++) begin
            if (i != cur) begin
                @(posedge clock);
                #1;
            end
            if (tx !== bits[i / (div + 1)]) begin
                slot_ok = 1'b0;
                bad_val = tx;
            end
            if ((i % (div + 1)) == div) begin
                checks++;
                if (!slot_ok) begin
                    errors++;
                    $display("FAIL %s bit%0d: tx=%b expected %b", name,
                             i / (div + 1), bad_val, bits[i / (div + 1)]);
                end
                slot_ok = 1'b1;
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        check_bit(tx, 1'b1, "rst_tx_idle");
        check_bit(tx_irq, 1'b1, "rst_irq");
        check_read(A_STATUS, 32'h0000_0001, "rst_status");
        check_read(A_DIV, 32'h0000_0003, "rst_divisor");
        // Disturb state, then reset asynchronously between edges
        bus_write(A_DIV, 32'h0000_0007, 4'b0011);
        bus_write(A_DATA, 32'h0000_0000, 4'b0001);
        repeat (4) @(posedge clock);
        #1;
        check_bit(tx, 1'b0, "rst_pre_tx_low");
        #3 reset = 1'b1;
        #1;
        check_bit(tx, 1'b1, "rst_async_tx");
        check_bit(tx_irq, 1'b1, "rst_async_irq");
        check_read(A_STATUS, 32'h0000_0001, "rst_async_status");
        check_read(A_DIV, 32'h0000_0003, "rst_async_divisor");
        @(posedge clock);
        #1 reset = 1'b0;
    endtask

    task automatic test_single_byte();
        check_bit(tx_irq, 1'b1, "single_irq_before");
        bus_write(A_DATA, 32'h0000_0055, 4'b0001);
        check_bit(tx_irq, 1'b0, "single_irq_fall");
        wait_start("single_start");
        expect_frame(8'h55, 3, 0, "single_0x55");
        check_bit(tx_irq, 1'b0, "single_irq_in_stop");
        @(posedge clock);
        #1;
        check_bit(tx_irq, 1'b1, "single_irq_rise_40");
        check_bit(tx, 1'b1, "single_tx_idle");
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 10; k++) begin
            bus_write(A_DATA, 32'(k), 4'b0001);
        end
        // count=8, full=1, overflow=1, tx_done=0; first frame is in cycle 8
        check_read(A_STATUS, 32'h0000_0806, "b2b_status_full");
        expect_frame(8'h00, 3, 8, "b2b_frame0");
        for (int k = 1; k < 9; k++) begin
            expect_frame(8'(k), 3, -1, $sformatf("b2b_frame%0d", k));
        end
        @(posedge clock);
        #1;
        check_bit(tx_irq, 1'b1, "b2b_irq_end");
        check_read(A_STATUS, 32'h0000_0005, "b2b_overflow_sticky");
        bus_write(A_STATUS, 32'h0000_0004, 4'b0001);
        check_read(A_STATUS, 32'h0000_0001, "b2b_overflow_clear");
    endtask

    task automatic test_divisor_change();
        bus_write(A_DATA, 32'h0000_00A5, 4'b0001);
        bus_write(A_DATA, 32'h0000_003C, 4'b0001);
        // Now in cycle 0 of the 0xA5 frame
        bus_write(A_DIV, 32'h0000_0001, 4'b0011);
        check_read(A_DIV, 32'h0000_0001, "div_readback");
        expect_frame(8'hA5, 3, 1, "div_old_frame");
        expect_frame(8'h3C, 1, -1, "div_new_frame");
        @(posedge clock);
        #1;
        check_bit(tx_irq, 1'b1, "div_irq_end");
        bus_write(A_DIV, 32'h0000_0003, 4'b0011);
    endtask

    task automatic test_decode();
        logic [31:0] got;
        check_read(32'h1000_0010, 32'h0000_0000, "dec_outside_read");
        bus_read(A_STATUS, 1'b0, got);
        checks++;
        if (got !== 32'h0) begin
            errors++;
            $display("FAIL dec_no_read_enable: read 0x%08h expected 0x00000000", got);
        end
        bus_write(A_RSVD, 32'hFFFF_FFFF, 4'b1111);
        bus_write(32'h1000_0018, 32'h0000_1234, 4'b1111);
        bus_write(32'h1000_0010, 32'h0000_0077, 4'b1111);
        @(posedge clock);
        #1;
        check_bit(tx, 1'b1, "dec_no_tx");
        check_read(A_STATUS, 32'h0000_0001, "dec_status_unchanged");
        check_read(A_DIV, 32'h0000_0003, "dec_div_unchanged");
        check_read(32'h1000_000B, 32'h0000_0003, "dec_low_bits_ignored");
        check_read(A_RSVD, 32'h0000_0000, "dec_reserved_read");
        check_read(A_DATA, 32'h0000_0000, "dec_data_read");
        bus_write(A_DIV, 32'h0000_AB00, 4'b0010);
        check_read(A_DIV, 32'h0000_AB03, "dec_div_lane1");
        bus_write(A_DIV, 32'h0000_0003, 4'b0011);
    endtask

    task automatic test_reset_mid_frame();
        bus_write(A_DATA, 32'h0000_0000, 4'b0001);
        bus_write(A_DATA, 32'h0000_0000, 4'b0001);
        // Frame started at the second write; move into the DATA bits
        repeat (6) @(posedge clock);
        #1;
        check_bit(tx, 1'b0, "midrst_pre_data_low");
        check_read(A_STATUS, 32'h0000_0100, "midrst_pre_count");
        #2 reset = 1'b1;
        #1;
        check_bit(tx, 1'b1, "midrst_tx_high");
        check_read(A_STATUS, 32'h0000_0001, "midrst_fifo_empty");
        @(posedge clock);
        #1 reset = 1'b0;
        begin
            int bad;
            bad = 0;
            for (int i = 0; i < 60; i++) begin
                @(posedge clock);
                #1;
                if (tx !== 1'b1 || tx_irq !== 1'b1) bad++;
            end
            checks++;
            if (bad != 0) begin
                errors++;
                $display("FAIL midrst_no_residual: %0d cycles with activity, expected 0", bad);
            end
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        reset  = 1'b1;
        bus_if.bus_address      = '0;
        bus_if.bus_write_data   = '0;
        bus_if.bus_byte_enable  = '0;
        bus_if.bus_read_enable  = 1'b0;
        bus_if.bus_write_enable = 1'b0;

        test_reset();
        test_single_byte();
        test_back_to_back();
        test_divisor_change();
        test_decode();
        test_reset_mid_frame();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
